// File: rtl/phase_ramp_mod_gen.sv
// Serrodyne phase ramp plus two-level square-wave bias modulation for the phase-modulator DAC.
// o_dac is registered (1-cycle lag behind state/ramp); o_step_trig pulses on the last LOW cycle of each period.
module phase_ramp_mod_gen #(
   parameter int DAC_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_ramp_en,
   input  logic [CNT_W-1:0] i_half_period,
   input  logic [DAC_W-1:0] i_mod_high,
   input  logic [DAC_W-1:0] i_mod_low,
   input  logic [DAC_W-1:0] i_step,
   output logic [DAC_W-1:0] o_dac,
   output logic             o_step_trig,
   output logic [1:0]       o_mod_state,
   output logic [DAC_W-1:0] o_ramp,
   output logic             o_wrap
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] tau, tau_nxt;
   logic [CNT_W-1:0] tau_in;
   logic [DAC_W-1:0] ramp, ramp_nxt;
   logic [DAC_W-1:0] dac;
   logic [DAC_W-1:0] offset;
   logic [DAC_W:0]   sum_ext;
   logic             wrap, wrap_nxt;
   logic             trig;
   logic             half_end;

   // Half-periods below 2 would collapse the HIGH/LOW phases, so clamp them.
   assign tau_in   = (i_half_period < CNT_W'(2)) ? CNT_W'(2) : i_half_period;
   assign half_end = (cnt == tau - CNT_W'(1));
   assign sum_ext  = {ramp[DAC_W-1], ramp} + {i_step[DAC_W-1], i_step};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tau_nxt   = tau;
      ramp_nxt  = ramp;
      wrap_nxt  = 1'b0;
      trig      = 1'b0;
      offset    = '0;
      case (state)
         IDLE: begin
            if (i_en) begin
               state_nxt = HIGH;
               tau_nxt   = tau_in;
               cnt_nxt   = '0;
            end
         end
         HIGH: begin
            offset = i_mod_high;
            if (half_end) begin
               cnt_nxt   = '0;
               state_nxt = LOW;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         LOW: begin
            offset = i_mod_low;
            if (half_end) begin
               trig    = 1'b1;
               cnt_nxt = '0;
               // Overflow shows as disagreement between the extended sign and the result sign.
               if (i_ramp_en) begin
                  ramp_nxt = sum_ext[DAC_W-1:0];
                  wrap_nxt = sum_ext[DAC_W] ^ sum_ext[DAC_W-1];
               end else begin
                  ramp_nxt = '0;
               end
               if (i_en) begin
                  state_nxt = HIGH;
                  tau_nxt   = tau_in;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
         tau   <= CNT_W'(2);
         ramp  <= '0;
         wrap  <= 1'b0;
         dac   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tau   <= tau_nxt;
         ramp  <= ramp_nxt;
         wrap  <= wrap_nxt;
         dac   <= ramp + offset;
      end
   end

   assign o_dac       = dac;
   assign o_step_trig = trig;
   assign o_mod_state = state;
   assign o_ramp      = ramp;
   assign o_wrap      = wrap;

endmodule
